// File: rtl/bship_pkg.sv
// Shared Battleship definitions: grid size, cursor width, debouncer states and
// the wrap-around step helper used by the cursor registers.
package bship_pkg;

    localparam int GRID_N   = 10;
    localparam int CURSOR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    // One grid step with explicit-compare wrap; opposing steps cancel.
    function automatic logic [CURSOR_W-1:0] wrap_step(
        input logic [CURSOR_W-1:0] value,
        input logic                dec,
        input logic                inc,
        input logic [CURSOR_W-1:0] last
    );
        logic [CURSOR_W-1:0] result;
        result = value;
        if (dec && !inc) begin
            result = (value == '0) ? last : value - CURSOR_W'(1);
        end else if (inc && !dec) begin
            result = (value == last) ? '0 : value + CURSOR_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/cursor_ctrl_if.sv
// Button/enable inputs and cursor outputs between the board I/O and cursor_ctrl.
interface cursor_ctrl_if;
    import bship_pkg::*;

    logic                btn_u;
    logic                btn_d;
    logic                btn_l;
    logic                btn_r;
    logic                btn_c_raw;
    logic                enable;
    logic [CURSOR_W-1:0] sprite_row;
    logic [CURSOR_W-1:0] sprite_col;
    logic                btn_c;
    logic                moved;

    modport master (
        output btn_u, btn_d, btn_l, btn_r, btn_c_raw, enable,
        input  sprite_row, sprite_col, btn_c, moved
    );

    modport slave (
        input  btn_u, btn_d, btn_l, btn_r, btn_c_raw, enable,
        output sprite_row, sprite_col, btn_c, moved
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM and optional hold-to-repeat.
// `step` pulses once on a debounced press and then on each repeat interval.
module btn_debounce
    import bship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 15000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic step
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LIM    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(REPEAT_RATE);

    logic             sync1_reg;
    logic             sync2_reg;
    db_state_t        state_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic             level_reg;
    logic             step_reg;

    logic [CNT_W-1:0] db_inc;
    logic             press_evt;
    logic             rep_fire;

    // The first sample of a new candidate level counts as one.
    assign db_inc    = (state_reg == IDLE || state_reg == HELD) ? ONE : db_cnt_reg + ONE;
    assign press_evt = (state_reg == IDLE || state_reg == PRESS_WAIT) && sync2_reg &&
                       (db_inc >= DB_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            state_reg  <= IDLE;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            step_reg   <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            step_reg  <= press_evt || rep_fire;
            unique case (state_reg)
                IDLE, PRESS_WAIT: begin
                    if (!sync2_reg) begin
                        state_reg  <= IDLE;
                        db_cnt_reg <= '0;
                    end else if (db_inc >= DB_LIM) begin
                        state_reg  <= HELD;
                        level_reg  <= 1'b1;
                        db_cnt_reg <= '0;
                    end else begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= db_inc;
                    end
                end
                HELD, RELEASE_WAIT: begin
                    if (sync2_reg) begin
                        state_reg  <= HELD;
                        db_cnt_reg <= '0;
                    end else if (db_inc >= DB_LIM) begin
                        state_reg  <= IDLE;
                        level_reg  <= 1'b0;
                        db_cnt_reg <= '0;
                    end else begin
                        state_reg  <= RELEASE_WAIT;
                        db_cnt_reg <= db_inc;
                    end
                end
            endcase
        end
    end

    // Repeat counter only advances while HELD; a bounce through RELEASE_WAIT pauses it.
    generate
        if (REPEAT_EN) begin : g_rep
            logic [CNT_W-1:0] rep_cnt_reg;
            logic             rep_first_reg;
            logic [CNT_W-1:0] rep_inc;
            logic [CNT_W-1:0] rep_lim;

            assign rep_inc  = rep_cnt_reg + ONE;
            assign rep_lim  = rep_first_reg ? DELAY_LIM : RATE_LIM;
            assign rep_fire = (state_reg == HELD) && sync2_reg && (rep_inc >= rep_lim);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rep_cnt_reg   <= '0;
                    rep_first_reg <= 1'b1;
                end else if (press_evt) begin
                    rep_cnt_reg   <= '0;
                    rep_first_reg <= 1'b1;
                end else if (state_reg == HELD && sync2_reg) begin
                    if (rep_inc >= rep_lim) begin
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b0;
                    end else begin
                        rep_cnt_reg <= rep_inc;
                    end
                end
            end
        end else begin : g_no_rep
            assign rep_fire = 1'b0;
        end
    endgenerate

    assign level = level_reg;
    assign step  = step_reg;

endmodule

// File: rtl/cursor_ctrl.sv
// Debounces the five game buttons and moves the wrap-around grid cursor that
// feeds game_state and the sprite overlay.
module cursor_ctrl
    import bship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 15000000,
    parameter int GRID_N          = bship_pkg::GRID_N
) (
    input  logic         clk,
    input  logic         reset_n,
    cursor_ctrl_if.slave bus
);

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    localparam logic [CURSOR_W-1:0] LAST = CURSOR_W'(GRID_N - 1);

    logic [4:0]          raw_vec;
    logic [4:0]          level_vec;
    logic [4:0]          step_vec;
    logic [3:0]          unused_dir_level;
    logic [CURSOR_W-1:0] row_reg;
    logic [CURSOR_W-1:0] col_reg;
    logic                moved_reg;
    logic [CURSOR_W-1:0] row_next;
    logic [CURSOR_W-1:0] col_next;

    assign raw_vec = {bus.btn_c_raw, bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .REPEAT_EN       (gi != BTN_C)
            ) u_db (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (raw_vec[gi]),
                .level   (level_vec[gi]),
                .step    (step_vec[gi])
            );
        end
    endgenerate

    // Direction levels are not needed here; only their steps move the cursor.
    assign unused_dir_level = level_vec[BTN_R:BTN_U];

    always_comb begin
        row_next = wrap_step(row_reg, step_vec[BTN_U], step_vec[BTN_D], LAST);
        col_next = wrap_step(col_reg, step_vec[BTN_L], step_vec[BTN_R], LAST);
    end

    // Steps arriving while disabled are dropped, never queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_reg   <= '0;
            col_reg   <= '0;
            moved_reg <= 1'b0;
        end else begin
            moved_reg <= 1'b0;
            if (bus.enable) begin
                row_reg   <= row_next;
                col_reg   <= col_next;
                moved_reg <= (row_next != row_reg) || (col_next != col_reg);
            end
        end
    end

    assign bus.sprite_row = row_reg;
    assign bus.sprite_col = col_reg;
    assign bus.btn_c      = level_vec[BTN_C];
    assign bus.moved      = moved_reg;

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Upstream input stage for `game_state`. It synchronises and debounces the five raw push-buttons (up, down, left, right, centre), then moves a 10x10 grid cursor with wrap-around and hold-to-repeat. It drives `sprite_row`, `sprite_col` and a clean `btn_c` level, which `game_state` edge-detects itself. The same row/col also feed the VGA sprite overlay.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synced samples required before a debounced level changes (5 ms at 100 MHz).
- `REPEAT_DELAY`, default 50000000: cycles a direction must be held after its press step before the first repeat step.
- `REPEAT_RATE`, default 15000000: cycles between subsequent repeat steps.
- `GRID_N`, default 10: grid dimension. Cursor range is 0..GRID_N-1.

Ports:
- `clk` (in, 1): system clock.
- `reset_n` (in, 1): reset, asynchronous and active-low.
- `btn_u`, `btn_d`, `btn_l`, `btn_r`, `btn_c_raw` (in, 1 each): raw, asynchronous button levels, active-high.
- `enable` (in, 1): 1 allows cursor motion; 0 freezes the cursor.
- `sprite_row` (out, 4): cursor row.
- `sprite_col` (out, 4): cursor column.
- `btn_c` (out, 1): debounced centre level.
- `moved` (out, 1): one-cycle pulse, high in the cycle the cursor changed.

## Operation
- **Reset (`reset_n` low).** All registers clear asynchronously: synchronisers, debounce counters, repeat counters, `sprite_row`=0, `sprite_col`=0, `btn_c`=0, `moved`=0. Every debouncer returns to IDLE.
- **Synchronisers.** Each raw input passes through a 2-flop synchroniser.
- **Debouncer states, per button.**
  - IDLE (level 0): go to PRESS_WAIT when the synced input is 1.
  - PRESS_WAIT: count consecutive 1s. A 0 returns to IDLE and clears the count. When the count reaches `DEBOUNCE_CYCLES`, go to HELD, set level=1, and pulse `step` for one cycle.
  - HELD (level 1): go to RELEASE_WAIT when the synced input is 0. While in HELD the repeat counter runs: it pulses `step` at `REPEAT_DELAY` cycles after the press step, then every `REPEAT_RATE` cycles.
  - RELEASE_WAIT: count consecutive 0s. A 1 returns to HELD; the repeat counter resumes without clearing. At `DEBOUNCE_CYCLES`, go to IDLE with level=0.
- **Centre button.** Repeat is disabled. `btn_c` equals the centre debouncer's level.
- **Row update (every cycle, `enable`=1).**
  - Up step only: row becomes row-1, wrapping 0 to GRID_N-1.
  - Down step only: row becomes row+1, wrapping GRID_N-1 to 0.
  - Up and down steps in the same cycle: no row change.
- **Column update.** Left/right work the same way on the column. Row and column can both change in one cycle.
- **`enable`=0.** Steps are discarded and not queued. Debouncing and repeat counting continue.
- **`moved`.** Registered. High for one cycle exactly when `sprite_row` or `sprite_col` changed on that edge. Low if a step was cancelled out or discarded.
- **Arithmetic.** Counters are sized as `$clog2(max param)+1`. Wrap is an explicit compare, never a modulo operation.

## Timing
- Raw rising edge to new cursor value is `DEBOUNCE_CYCLES`+3 clocks: 2 for synchronisation, `DEBOUNCE_CYCLES` for debounce, 1 for the register.
- `btn_c` rises `DEBOUNCE_CYCLES`+2 clocks after the raw edge. Release has the same latency.
- `moved` is coincident with the new cursor value.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no step and no `btn_c` change.
- If `reset_n` is asserted mid-hold, the debouncer goes to IDLE. After release, a still-held button requires a full press debounce before it steps again.

## Structure
- **Package `bship_pkg`:** `GRID_N`, the debouncer state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), and the cursor width constant. `game_state` and the renderer share these.
- **Sub-module `btn_debounce`:** synchroniser, debounce FSM and optional repeat counter (parameter `REPEAT_EN`). It outputs `level` and `step`. `cursor_ctrl` instantiates it five times and adds the cursor registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=5.

- **Press latency:** hold `btn_d` from reset (row 0) -> row=1 and `moved`=1 exactly 7 clocks after the raw edge. Nothing changes before that.
- **Glitch rejection:** pulse `btn_r` high for 3 cycles -> col unchanged, `moved` never asserts.
- **Wrap-around:** from row 0, one `btn_u` press -> row=9. From col 9, one `btn_r` press -> col=0.
- **Hold-to-repeat:** hold `btn_d` for 30 cycles after the press step -> steps at +0, +10, +15, +20, +25, +30 give row=6 from 0. Release -> no further steps.
- **Simultaneous:** `btn_l` and `btn_r` raw edges on the same cycle -> col unchanged, `moved`=0. `btn_u` with `btn_r` -> row and col both change in one cycle.
- **Enable, reset and centre:**
  - With `enable`=0, press `btn_d` -> row unchanged.
  - Raise `enable` while still holding -> the next repeat step moves the cursor.
  - Pull `reset_n` low mid-hold -> row=col=0 and `btn_c`=0 immediately.
  - Hold `btn_c_raw` -> `btn_c`=1 after 6 clocks and no repeat pulses.
